// File: rtl/dma_xfer_buffer.sv
// DMA copy engine: halts the core, reads LEN words from a source page into a DEPTH-entry buffer, drains them to DST_ADDR.
// Bus outputs decode from registered state (no input-to-output paths); rdy=0 freezes every non-idle state.

// Single-clock FIFO, head visible combinationally; caller guarantees no overflow/underflow.
module dma_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic                       CLK,
  input  logic                       n_RES,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [0:(1<<PW)-1];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= wrap_inc(wr_ptr);
      count  <= count + CW'(1);
    end else if (pop) begin
      rd_ptr <= wrap_inc(rd_ptr);
      count  <= count - CW'(1);
    end
  end

  assign rdata = mem[rd_ptr];
endmodule

module dma_xfer_buffer #(
  parameter int            DW       = 8,
  parameter int            AW       = 16,
  parameter int            LEN      = 256,
  parameter int            DEPTH    = 1,
  parameter logic [AW-1:0] DST_ADDR = 16'h2004
) (
  input  logic          CLK,
  input  logic          n_RES,
  input  logic          start,
  input  logic [AW-9:0] src_page,
  input  logic          rdy,
  input  logic          odd,
  input  logic [DW-1:0] din,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] dout,
  output logic          drive_en,
  output logic          rnw,
  output logic          halt,
  output logic          busy,
  output logic          done
);
  localparam int CW  = $clog2(LEN+1);
  localparam int PGW = AW - 8;
  localparam int FCW = $clog2(DEPTH+1);

  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [PGW-1:0] page;
  logic [CW-1:0]  rd_cnt;
  logic [CW-1:0]  wr_cnt;
  logic [FCW-1:0] fcnt;
  logic [DW-1:0]  head;
  logic           push;
  logic           pop;
  logic           rd_last;
  logic           wr_last;
  logic           fill_last;
  logic           drain_last;

  assign push       = (state == READ)  && rdy;
  assign pop        = (state == WRITE) && rdy;
  assign rd_last    = (rd_cnt == CW'(LEN-1));
  assign wr_last    = (wr_cnt == CW'(LEN-1));
  // Phase switches look at the count the push/pop is about to produce.
  assign fill_last  = (fcnt == FCW'(DEPTH-1));
  assign drain_last = (fcnt == FCW'(1));

  dma_fifo #(.W(DW), .DEPTH(DEPTH)) u_fifo (
    .CLK   (CLK),
    .n_RES (n_RES),
    .push  (push),
    .pop   (pop),
    .wdata (din),
    .rdata (head),
    .count (fcnt)
  );

  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = HALT;
      HALT:  if (rdy) state_nxt = odd ? ALIGN : READ;
      ALIGN: if (rdy) state_nxt = READ;
      READ:  if (rdy && (fill_last || rd_last)) state_nxt = WRITE;
      WRITE: begin
        if (rdy) begin
          if (wr_last)         state_nxt = IDLE;
          else if (drain_last) state_nxt = READ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    addr     = '0;
    dout     = '0;
    rnw      = 1'b1;
    drive_en = 1'b0;
    case (state)
      HALT, ALIGN, READ: addr = {page, PGW'(rd_cnt)};
      WRITE: begin
        addr     = DST_ADDR;
        rnw      = 1'b0;
        drive_en = 1'b1;
        dout     = head;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);
  assign halt = busy;

  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      page   <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
      done   <= 1'b0;
    end else begin
      done <= pop && wr_last;
      if ((state == IDLE) && start) begin
        page   <= src_page;
        rd_cnt <= '0;
        wr_cnt <= '0;
      end
      if (push) rd_cnt <= rd_cnt + CW'(1);
      if (pop)  wr_cnt <= wr_cnt + CW'(1);
    end
  end
endmodule
